// File: rtl/iod_train_pkg.sv
// Shared definitions for the IOD eye-monitor clock-training sequencer:
// the FSM state encoding, pulse levels and a counter-width helper.
package iod_train_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_LWAIT  = 4'd2,
    ST_CLEAR  = 4'd3,
    ST_SETTLE = 4'd4,
    ST_SAMPLE = 4'd5,
    ST_EVAL   = 4'd6,
    ST_STEP   = 4'd7,
    ST_CLOAD  = 4'd8,
    ST_CWAIT  = 4'd9,
    ST_CSTEP  = 4'd10,
    ST_DONE   = 4'd11,
    ST_ERR    = 4'd12
  } train_state_e;

  localparam logic PULSE_ON  = 1'b1;
  localparam logic PULSE_OFF = 1'b0;

  // One down-counter serves both the settle and the sample windows, so it
  // must be wide enough for the larger of the two reload values.
  function automatic int wait_cnt_width(input int settle, input int sample);
    int m;
    m = (settle > sample) ? settle : sample;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iod_train_wait_cnt.sv
// Reloadable down-counter timing the settle and sample windows. After a load
// of N it counts N, N-1, ..., 1 and then holds at 0; `last` marks the final
// cycle of the window, so a window loaded with N lasts exactly N cycles.
module iod_train_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/iod_clk_train_ctrl.sv
// Eye-monitor clock-training sequencer for one RX IOD lane. Sweeps the delay
// line from tap 0 to MAX_TAP, samples the EARLY/LATE flags at each tap, keeps
// the first longest run of clean taps, then reloads the delay line and steps
// it to the centre of that run.
//
// Handshake: TRAIN_START is a one-cycle request with no ready; it is accepted
// only in IDLE, and BUSY high means any request is dropped. Completion is
// reported by the TRAIN_DONE / TRAIN_ERR levels, which hold until the next
// accepted start.
module iod_clk_train_ctrl
  import iod_train_pkg::*;
#(
  parameter int TAP_W         = 8,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 64,
  parameter int MIN_EYE       = 4
) (
  input  logic               FAB_CLK,
  input  logic               ARST_N,
  input  logic               TRAIN_START,
  input  logic               EYE_MONITOR_EARLY,
  input  logic               EYE_MONITOR_LATE,
  input  logic               DELAY_LINE_OUT_OF_RANGE,
  output logic               EYE_MONITOR_CLEAR_FLAGS,
  output logic               DELAY_LINE_LOAD,
  output logic               DELAY_LINE_MOVE,
  output logic               DELAY_LINE_DIRECTION,
  output logic               BUSY,
  output logic               TRAIN_DONE,
  output logic               TRAIN_ERR,
  output logic [TAP_W-1:0]   EYE_START,
  output logic [TAP_W:0]     EYE_WIDTH,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int                WAIT_W    = wait_cnt_width(SETTLE_CYCLES, SAMPLE_CYCLES);
  localparam logic [WAIT_W-1:0] SETTLE_LD = WAIT_W'(SETTLE_CYCLES);
  localparam logic [WAIT_W-1:0] SAMPLE_LD = WAIT_W'(SAMPLE_CYCLES);
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W:0]    MIN_LEN   = (TAP_W+1)'(MIN_EYE);

  train_state_e      state;
  logic [TAP_W-1:0]  tap;
  logic [TAP_W-1:0]  run_start;
  logic [TAP_W:0]    run_len;
  logic [TAP_W-1:0]  best_start;
  logic [TAP_W:0]    best_len;
  logic [TAP_W:0]    remain;
  logic              bad;

  logic              wait_load;
  logic [WAIT_W-1:0] wait_val;
  logic              wait_last;

  logic [TAP_W:0]    ext_len;
  logic [TAP_W-1:0]  ext_start;
  logic [TAP_W:0]    close_len;
  logic [TAP_W-1:0]  close_start;
  logic              take_best;
  logic [TAP_W:0]    centre;
  logic              in_busy;

  assign dbg_state = state;
  assign in_busy   = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);

  iod_train_wait_cnt #(.W(WAIT_W)) u_wait (
    .clk      (FAB_CLK),
    .rst_n    (ARST_N),
    .load     (wait_load),
    .load_val (wait_val),
    .last     (wait_last)
  );

  // Reload the window counter in the cycle before each timed state begins.
  always_comb begin
    wait_load = 1'b0;
    wait_val  = SETTLE_LD;
    case (state)
      ST_LOAD, ST_CLEAR, ST_CSTEP: wait_load = 1'b1;
      ST_SETTLE: begin
        if (wait_last) begin
          wait_load = 1'b1;
          wait_val  = SAMPLE_LD;
        end
      end
      ST_CLOAD: wait_load = (best_len >= MIN_LEN);
      default: ;
    endcase
  end

  // Run bookkeeping for the tap being evaluated: the run extended by a clean
  // tap, the run that closes here, and whether it beats the best so far.
  always_comb begin
    ext_len     = run_len + (TAP_W+1)'(1);
    ext_start   = (run_len == '0) ? tap : run_start;
    close_len   = bad ? run_len : ext_len;
    close_start = bad ? run_start : ext_start;
    take_best   = (bad || (tap == LAST_TAP)) && (close_len > best_len);
    centre      = {1'b0, best_start} + (best_len >> 1);
  end

  // Training sequencer: sweep, evaluate, centre; all outputs registered.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                   <= ST_IDLE;
      tap                     <= '0;
      run_start               <= '0;
      run_len                 <= '0;
      best_start              <= '0;
      best_len                <= '0;
      remain                  <= '0;
      bad                     <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= PULSE_OFF;
      DELAY_LINE_LOAD         <= PULSE_OFF;
      DELAY_LINE_MOVE         <= PULSE_OFF;
      DELAY_LINE_DIRECTION    <= 1'b0;
      BUSY                    <= 1'b0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
      EYE_START               <= '0;
      EYE_WIDTH               <= '0;
    end else begin
      EYE_MONITOR_CLEAR_FLAGS <= PULSE_OFF;
      DELAY_LINE_LOAD         <= PULSE_OFF;
      DELAY_LINE_MOVE         <= PULSE_OFF;
      if (in_busy && DELAY_LINE_OUT_OF_RANGE) begin
        state                <= ST_ERR;
        TRAIN_ERR            <= 1'b1;
        BUSY                 <= 1'b0;
        DELAY_LINE_DIRECTION <= 1'b0;
        EYE_START            <= best_start;
        EYE_WIDTH            <= best_len;
      end else begin
        case (state)
          ST_IDLE: begin
            if (TRAIN_START) begin
              state                <= ST_LOAD;
              TRAIN_DONE           <= 1'b0;
              TRAIN_ERR            <= 1'b0;
              EYE_START            <= '0;
              EYE_WIDTH            <= '0;
              tap                  <= '0;
              run_start            <= '0;
              run_len              <= '0;
              best_start           <= '0;
              best_len             <= '0;
              remain               <= '0;
              BUSY                 <= 1'b1;
              DELAY_LINE_DIRECTION <= 1'b1;
              DELAY_LINE_LOAD      <= PULSE_ON;
            end
          end
          ST_LOAD: state <= ST_LWAIT;
          ST_LWAIT: begin
            if (wait_last) begin
              state                   <= ST_CLEAR;
              EYE_MONITOR_CLEAR_FLAGS <= PULSE_ON;
            end
          end
          ST_CLEAR: begin
            bad   <= 1'b0;
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (wait_last) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            bad <= bad | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
            if (wait_last) state <= ST_EVAL;
          end
          ST_EVAL: begin
            if (take_best) begin
              best_start <= close_start;
              best_len   <= close_len;
            end
            if (bad) begin
              run_len <= '0;
            end else begin
              run_len   <= ext_len;
              run_start <= ext_start;
            end
            if (tap != LAST_TAP) begin
              tap             <= tap + TAP_W'(1);
              DELAY_LINE_MOVE <= PULSE_ON;
              state           <= ST_STEP;
            end else begin
              state <= ST_CLOAD;
            end
          end
          ST_STEP: begin
            state                   <= ST_CLEAR;
            EYE_MONITOR_CLEAR_FLAGS <= PULSE_ON;
          end
          ST_CLOAD: begin
            if (best_len < MIN_LEN) begin
              state                <= ST_ERR;
              TRAIN_ERR            <= 1'b1;
              BUSY                 <= 1'b0;
              DELAY_LINE_DIRECTION <= 1'b0;
              EYE_START            <= best_start;
              EYE_WIDTH            <= best_len;
            end else begin
              DELAY_LINE_LOAD <= PULSE_ON;
              remain          <= centre;
              state           <= ST_CWAIT;
            end
          end
          ST_CWAIT: begin
            if (wait_last) begin
              if (remain == '0) begin
                state                <= ST_DONE;
                TRAIN_DONE           <= 1'b1;
                BUSY                 <= 1'b0;
                DELAY_LINE_DIRECTION <= 1'b0;
                EYE_START            <= best_start;
                EYE_WIDTH            <= best_len;
              end else begin
                DELAY_LINE_MOVE <= PULSE_ON;
                remain          <= remain - (TAP_W+1)'(1);
                state           <= ST_CSTEP;
              end
            end
          end
          ST_CSTEP: state <= ST_CWAIT;
          ST_DONE, ST_ERR: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
